// File: rtl/spart_fifo.sv
// 8N1 UART on the processor I/O bus: programmable baud divisor, 16x RX oversampling, TX/RX FIFOs.
// Latency: reads are combinational; backpressure: a full TX FIFO drops writes, a full RX FIFO drops bytes and sets ovf.

module spart_fifo_buf #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdat,
    output logic [W-1:0] rdat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        do_push = push && ((cnt_q != FULL_CNT) || do_pop);
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wp_q] = wdat;
            wp_d        = wp_q + AW'(1);
        end
        if (do_pop) begin
            rp_d = rp_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    assign rdat  = mem_q[rp_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module spart_fifo #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd162
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic        wr, rd, tick, div_wr;
    logic [15:0] div_q, div_d, bcnt_q, bcnt_d;
    logic [7:0]  rd_dat;

    logic        tx_empty, tx_full, tx_pop;
    logic [7:0]  tx_rdat;
    state_t      tx_state_q, tx_state_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_load_q, tx_load_d, txd_q, txd_d, tx_idle;

    logic        sync1_q, sync2_q;
    logic        rx_empty, rx_full, rx_pop, rx_push;
    logic [7:0]  rx_rdat;
    state_t      rx_state_q, rx_state_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        ovf_q, ovf_d, ferr_q, ferr_d, ferr_set;

    assign wr     = iocs && !iorw;
    assign rd     = iocs && iorw;
    assign tick   = (bcnt_q == 16'd0);
    assign div_wr = wr && ioaddr[1];
    assign rx_pop = rd && (ioaddr == 2'b00);

    spart_fifo_buf #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr && (ioaddr == 2'b00)), .pop(tx_pop),
        .wdat(databus), .rdat(tx_rdat), .empty(tx_empty), .full(tx_full)
    );

    spart_fifo_buf #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop),
        .wdat(rx_shift_q), .rdat(rx_rdat), .empty(rx_empty), .full(rx_full)
    );

    always_comb begin
        div_d = div_q;
        if (div_wr && ioaddr[0]) div_d = {databus, div_q[7:0]};
        else if (div_wr)         div_d = {div_q[15:8], databus};
        if (div_wr)    bcnt_d = div_d;
        else if (tick) bcnt_d = div_q;
        else           bcnt_d = bcnt_q - 16'd1;
    end

    // TX: a byte is popped into the shifter as soon as one is available, then framing starts on the next tick.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_load_d  = tx_load_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            S_IDLE: begin
                if (!tx_load_q) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_rdat;
                        tx_load_d  = 1'b1;
                    end
                end else if (tick) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = 4'd0;
                    tx_load_d  = 1'b0;
                end
            end
            S_START: if (tick) begin
                tx_cnt_d = tx_cnt_q + 4'd1;
                if (tx_cnt_q == 4'd15) begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = 3'd0;
                end
            end
            S_DATA: if (tick) begin
                tx_cnt_d = tx_cnt_q + 4'd1;
                if (tx_cnt_q == 4'd15) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
                end
            end
            S_STOP: if (tick) begin
                tx_cnt_d = tx_cnt_q + 4'd1;
                if (tx_cnt_q == 4'd15) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_rdat;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        case (tx_state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // RX: start bit confirmed at its centre, then every 16th tick lands on a bit centre.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        unique case (rx_state_q)
            S_IDLE: if (!sync2_q) begin
                rx_state_d = S_START;
                rx_cnt_d   = 4'd0;
            end
            S_START: if (tick) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd7) begin
                    rx_state_d = sync2_q ? S_IDLE : S_DATA;
                    rx_cnt_d   = 4'd0;
                    rx_bit_d   = 3'd0;
                end
            end
            S_DATA: if (tick) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd15) begin
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end
            end
            S_STOP: if (tick) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd15) begin
                    rx_push    = sync2_q;
                    ferr_set   = !sync2_q;
                    rx_state_d = S_IDLE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    assign tx_idle = tx_empty && (tx_state_q == S_IDLE) && !tx_load_q;
    assign rda     = !rx_empty;
    assign tbr     = !tx_full;
    assign txd     = txd_q;

    always_comb begin
        ovf_d  = (ovf_q  && !(rd && ioaddr == 2'b01)) || (rx_push && rx_full && !rx_pop);
        ferr_d = (ferr_q && !(rd && ioaddr == 2'b01)) || ferr_set;
        case (ioaddr)
            2'b00:   rd_dat = rx_empty ? 8'h00 : rx_rdat;
            2'b01:   rd_dat = {ovf_q, ferr_q, 2'b00, tx_idle, rx_full, tbr, rda};
            2'b10:   rd_dat = div_q[7:0];
            default: rd_dat = div_q[15:8];
        endcase
    end

    assign databus = (iocs && iorw) ? rd_dat : 8'hzz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q      <= DIV_RESET;
            bcnt_q     <= DIV_RESET;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_load_q  <= 1'b0;
            txd_q      <= 1'b1;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            bcnt_q     <= bcnt_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_load_q  <= tx_load_d;
            txd_q      <= txd_d;
            sync1_q    <= rxd;
            sync2_q    <= sync1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
        end
    end
endmodule

// File: tb/tb_spart_fifo.sv
// Bench for spart_fifo: randomized traffic against a queue-based model of the UART and its FIFOs.
module tb_spart_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    wire  [7:0] databus;
    logic       drv_en = 1'b0;
    logic [7:0] drv_dat = 8'h00;
    logic       rda, tbr, txd, rxd;
    logic       loop = 1'b0;
    logic       rxd_drv = 1'b1;

    localparam int DEPTH = 8;

    assign databus = drv_en ? drv_dat : 8'hzz;
    assign rxd     = loop ? txd : rxd_drv;

    always #5 clk = ~clk;

    spart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd162)) dut (
        .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
    );

    int n_chk = 0;
    int n_pass = 0;
    int bitc = 16 * 163;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_dat = d; drv_en = 1'b1;
        @(negedge clk);
        iocs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #2 d = databus;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic set_div(input logic [15:0] dv);
        bus_wr(2'd2, dv[7:0]);
        bus_wr(2'd3, dv[15:8]);
        bitc = 16 * (int'(dv) + 1);
    endtask

    // Sample one frame from txd at bit centres; gap = cycles spent waiting for the start edge.
    task automatic decode(output logic [7:0] b, output bit ok, output int gap);
        ok = 1'b1; gap = 0; b = 8'h00;
        do begin
            @(negedge clk);
            gap++;
        end while (txd !== 1'b0 && gap < 4 * bitc);
        if (txd !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (bitc / 2) @(negedge clk);
        if (txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (bitc) @(negedge clk);
            b[i] = txd;
        end
        repeat (bitc) @(negedge clk);
        if (txd !== 1'b1) ok = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit good);
        rxd_drv = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (bitc) @(negedge clk);
        end
        if (good) begin
            rxd_drv = 1'b1;
            repeat (bitc) @(negedge clk);
        end else begin
            rxd_drv = 1'b0;
            repeat (bitc * 3 / 4) @(negedge clk);
            rxd_drv = 1'b1;
            repeat (bitc) @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] d, b;
        logic [7:0] v [10];
        logic [7:0] q [$];
        logic [15:0] dv;
        logic ovf_exp;
        bit ok;
        int gap, max_gap, lows, n, t, lo;

        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(1);
        check("rst_txd", txd, 1);
        check("rst_rda", rda, 0);
        check("rst_tbr", tbr, 1);
        bus_rd(2'd1, d); check("rst_status", d, 8'h0A);
        bus_rd(2'd2, d); check("rst_div_lo", d, 8'd162);
        bus_rd(2'd3, d); check("rst_div_hi", d, 8'd0);

        set_div(16'd3);
        bus_rd(2'd2, d); check("div_lo", d, 8'd3);
        bus_rd(2'd3, d); check("div_hi", d, 8'd0);

        // Single 0x55 frame: start bit width and bit pattern.
        t = 0; lo = 0; b = 8'h00;
        fork
            bus_wr(2'd0, 8'h55);
            begin
                while (txd !== 1'b0 && t < 200) begin @(negedge clk); t++; end
                check("t55_start_seen", txd, 0);
                while (txd === 1'b0 && lo < 200) begin @(negedge clk); lo++; end
                check("t55_start_len", (lo >= 60 && lo <= 68), 1);
                repeat (bitc / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    b[i] = txd;
                    repeat (bitc) @(negedge clk);
                end
                check("t55_data", b, 8'h55);
                check("t55_stop", txd, 1);
            end
        join
        wait_clk(bitc);

        // Ten back-to-back writes: shifter plus FIFO absorb nine, the tenth is dropped.
        for (int i = 0; i < 10; i++) v[i] = 8'($urandom);
        q.delete();
        for (int i = 0; i < DEPTH + 1; i++) q.push_back(v[i]);
        max_gap = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) bus_wr(2'd0, v[i]);
                check("tx_tbr_full", tbr, 0);
            end
            begin
                for (int k = 0; k < DEPTH + 1; k++) begin
                    decode(b, ok, gap);
                    check("tx_frame_ok", ok, 1);
                    check("tx_byte", b, q.pop_front());
                    if (k > 0 && gap > max_gap) max_gap = gap;
                end
            end
        join
        check("tx_contiguous", (max_gap <= 34), 1);
        lows = 0;
        repeat (20 * bitc) begin @(negedge clk); if (txd === 1'b0) lows++; end
        check("tx_10th_dropped", lows, 0);
        bus_rd(2'd1, d); check("tx_done_status", d, 8'h0A);

        // Loopback: fixed pair then a random burst at a random divisor.
        loop = 1'b1;
        bus_wr(2'd0, 8'hA5);
        bus_wr(2'd0, 8'h3C);
        wait_clk(2 * 10 * bitc + 100);
        check("lb_rda", rda, 1);
        bus_rd(2'd0, d); check("lb_rd0", d, 8'hA5);
        bus_rd(2'd0, d); check("lb_rd1", d, 8'h3C);
        bus_rd(2'd0, d); check("lb_empty_rd", d, 8'h00);
        check("lb_rda_clear", rda, 0);

        dv = 16'($urandom_range(1, 4));
        set_div(dv);
        bus_rd(2'd2, d); check("lb_div_lo", d, dv[7:0]);
        n = $urandom_range(3, 6);
        q.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            bus_wr(2'd0, b);
        end
        wait_clk(n * 10 * bitc + 200);
        for (int i = 0; i < n; i++) begin
            bus_rd(2'd0, d);
            check("lb_rand", d, q.pop_front());
        end
        bus_rd(2'd1, d); check("lb_status", d, 8'h0A);

        // RX overflow: nine frames, no reads.
        set_div(16'd3);
        q.delete();
        ovf_exp = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (q.size() < DEPTH) q.push_back(b);
            else ovf_exp = 1'b1;
            bus_wr(2'd0, b);
        end
        wait_clk((DEPTH + 1) * 10 * bitc + 200);
        bus_rd(2'd1, d);
        check("ovf_status", d, {ovf_exp, 1'b0, 2'b00, 1'b1, q.size() == DEPTH, 1'b1, q.size() > 0});
        bus_rd(2'd1, d);
        check("ovf_cleared", d, {1'b0, 1'b0, 2'b00, 1'b1, q.size() == DEPTH, 1'b1, q.size() > 0});
        n = q.size();
        for (int i = 0; i < n; i++) begin
            bus_rd(2'd0, d);
            check("ovf_data", d, q.pop_front());
        end
        bus_rd(2'd0, d); check("ovf_drained", d, 8'h00);
        bus_rd(2'd1, d); check("ovf_end_status", d, 8'h0A);

        // Bench-driven RX frames: good, bad stop bit, glitch, good.
        loop = 1'b0;
        wait_clk(bitc);
        b = 8'($urandom);
        drive_frame(b, 1'b1);
        wait_clk(bitc);
        bus_rd(2'd1, d); check("rx_good_status", d, 8'h0B);
        bus_rd(2'd0, d); check("rx_good_data", d, b);
        drive_frame(8'($urandom), 1'b0);
        wait_clk(2 * bitc);
        check("ferr_no_push", rda, 0);
        bus_rd(2'd1, d); check("ferr_status", d, 8'h4A);
        bus_rd(2'd1, d); check("ferr_cleared", d, 8'h0A);
        rxd_drv = 1'b0;
        wait_clk(bitc / 4);
        rxd_drv = 1'b1;
        wait_clk(12 * bitc);
        check("glitch_rda", rda, 0);
        bus_rd(2'd1, d); check("glitch_status", d, 8'h0A);
        b = 8'($urandom);
        drive_frame(b, 1'b1);
        wait_clk(bitc);
        bus_rd(2'd0, d); check("rx_after_glitch", d, b);

        // Reset in the middle of a transmitted byte.
        bus_wr(2'd0, 8'h00);
        bus_wr(2'd0, 8'h00);
        bus_wr(2'd0, 8'hFF);
        wait_clk(8 * bitc);
        check("mid_tx_low", txd, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 check("mid_rst_txd", txd, 1);
        @(negedge clk);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(1);
        bus_rd(2'd1, d); check("post_rst_status", d, 8'h0A);
        bus_rd(2'd2, d); check("post_rst_div", d, 8'd162);
        check("post_rst_tbr", tbr, 1);
        check("post_rst_rda", rda, 0);
        lows = 0;
        repeat (2000) begin @(negedge clk); if (txd === 1'b0) lows++; end
        check("post_rst_quiet", lows, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
